// File: rtl/pps_frequency_counter_pkg.sv
// pps_frequency_counter_pkg: shared FSM encoding and default widths for the PPS gate counter.
package pps_frequency_counter_pkg;
  typedef enum logic {IDLE = 1'b0, COUNTING = 1'b1} state_e;
  localparam int DEFAULT_COUNT_WIDTH = 36;
  localparam logic [DEFAULT_COUNT_WIDTH-1:0] DEFAULT_COUNT_MAX = '1;
endpackage

// File: rtl/pulse_synchronizer.sv
// pulse_synchronizer: multi-flop synchroniser for an asynchronous input, with a registered
// one-cycle rising-edge pulse (pin-to-pulse latency SYNC_STAGES+1 cycles).
module pulse_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic hist_q, hist_d, rise_q, rise_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
    end
  end
  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = rise_q;
endmodule

// File: rtl/pps_frequency_counter.sv
// pps_frequency_counter: counts system_clk cycles across gate_intervals+1 PPS intervals,
// with saturation, missing-pulse timeout, enable/abort and a valid/ack result handshake.
module pps_frequency_counter
  import pps_frequency_counter_pkg::*;
#(
  parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH,
  parameter int GATE_WIDTH    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT_WIDTH = 32
) (
  input  logic                     system_clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     pps_in,
  input  logic [GATE_WIDTH-1:0]    gate_intervals,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  output logic [COUNT_WIDTH-1:0]   result,
  output logic                     result_valid,
  input  logic                     result_ack,
  output logic                     result_overflow,
  output logic                     result_lost,
  output logic                     pps_missing
);
  localparam logic [COUNT_WIDTH-1:0]   CNT_MAX   = '1;
  localparam logic [TIMEOUT_WIDTH-1:0] SINCE_MAX = '1;
  state_e state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc, result_q, result_d;
  logic [GATE_WIDTH-1:0] intervals_q, intervals_d, gate_len_q, gate_len_d;
  logic [TIMEOUT_WIDTH-1:0] since_q, since_d;
  logic ovf_q, ovf_d, valid_q, valid_d, overflow_q, overflow_d, lost_q, lost_d, missing_q, missing_d;
  logic pps_edge, unused_level, cnt_sat, gate_close, timeout_hit, valid_after_ack;

  pulse_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (system_clk),
    .rst_n(reset_n),
    .din  (pps_in),
    .level(unused_level),
    .rise (pps_edge)
  );

  // since_q counts cycles elapsed since the edge-detect cycle, so it reads 1 the cycle after an edge
  always_comb begin
    cnt_sat         = cnt_q == CNT_MAX;
    cnt_inc         = cnt_sat ? cnt_q : cnt_q + COUNT_WIDTH'(1);
    since_d         = pps_edge ? TIMEOUT_WIDTH'(1) : (since_q == SINCE_MAX ? since_q : since_q + TIMEOUT_WIDTH'(1));
    timeout_hit     = enable && state_q == COUNTING && !pps_edge && timeout_cycles != '0 && since_d >= timeout_cycles;
    gate_close      = enable && state_q == COUNTING && pps_edge && intervals_q == gate_len_q;
    valid_after_ack = valid_q & ~result_ack;
    state_d         = state_q;
    cnt_d           = cnt_inc;
    ovf_d           = ovf_q | cnt_sat;
    intervals_d     = intervals_q;
    gate_len_d      = gate_len_q;
    if (!enable || timeout_hit) begin
      state_d = IDLE;
    end else if (pps_edge && (state_q == IDLE || intervals_q == gate_len_q)) begin
      state_d     = COUNTING;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      intervals_d = '0;
      gate_len_d  = gate_intervals;
    end else if (pps_edge) begin
      intervals_d = intervals_q + GATE_WIDTH'(1);
    end
    result_d   = gate_close ? cnt_inc : result_q;
    overflow_d = gate_close ? (ovf_q | cnt_sat) : overflow_q;
    valid_d    = gate_close | valid_after_ack;
    lost_d     = (lost_q & ~(result_ack & valid_q)) | (gate_close & valid_after_ack);
    missing_d  = pps_edge ? 1'b0 : (missing_q | timeout_hit);
  end

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      intervals_q <= '0;
      gate_len_q  <= '0;
      since_q     <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      lost_q      <= 1'b0;
      missing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      intervals_q <= intervals_d;
      gate_len_q  <= gate_len_d;
      since_q     <= since_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
      lost_q      <= lost_d;
      missing_q   <= missing_d;
    end
  end

  assign result          = result_q;
  assign result_valid    = valid_q;
  assign result_overflow = overflow_q;
  assign result_lost     = lost_q;
  assign pps_missing     = missing_q;
endmodule

// File: tb/tb_pps_frequency_counter.sv
// tb_pps_frequency_counter: directed table, hand sequences and random PPS traffic checked
// every cycle against a timestamp-based reference model.
module tb_pps_frequency_counter;
  localparam int CW = 10;
  localparam int GW = 4;
  localparam int TW = 32;
  localparam longint MAXC = (64'd1 << CW) - 1;
  localparam int FAR = 1 << 30;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic pps_in = 1'b0;
  logic result_ack = 1'b0;
  logic [GW-1:0] gate_intervals = '0;
  logic [TW-1:0] timeout_cycles = '0;
  logic [CW-1:0] result;
  logic result_valid, result_overflow, result_lost, pps_missing;

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;
  int next_e = FAR;
  int last_e = 0;

  bit m_open, m_valid, m_ovf, m_lost, m_miss;
  int m_topen, m_nedges, m_glen, m_last;
  longint m_res;

  typedef struct {
    int gi; int sp; int ne; int tmo; int tail;
    int res; int valid; int ovf; int miss;
  } vec_t;
  vec_t tbl[13];

  pps_frequency_counter #(
    .COUNT_WIDTH(CW), .GATE_WIDTH(GW), .SYNC_STAGES(2), .TIMEOUT_WIDTH(TW)
  ) dut (
    .system_clk     (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .pps_in         (pps_in),
    .gate_intervals (gate_intervals),
    .timeout_cycles (timeout_cycles),
    .result         (result),
    .result_valid   (result_valid),
    .result_ack     (result_ack),
    .result_overflow(result_overflow),
    .result_lost    (result_lost),
    .pps_missing    (pps_missing)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  function automatic logic [CW+3:0] pack(logic [CW-1:0] r, logic v, logic o, logic l, logic m);
    return {r, v, o, l, m};
  endfunction

  task automatic check(string name, logic [CW+3:0] act, logic [CW+3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s at cycle %0d: got {result,valid,ovf,lost,missing}=%h, want %h", name, n, act, exp);
    end
  endtask

  task automatic want(string name, int r, int v, int o, int l, int m);
    check(name, pack(result, result_valid, result_overflow, result_lost, pps_missing),
          pack(CW'(r), v != 0, o != 0, l != 0, m != 0));
  endtask

  task automatic model_reset();
    m_open = 0; m_valid = 0; m_ovf = 0; m_lost = 0; m_miss = 0;
    m_topen = 0; m_nedges = 0; m_glen = 0; m_last = n; m_res = 0;
  endtask

  // Gate results are differences of edge timestamps; a gate times out once the cycles since
  // the edge-detect cycle (the one before the consuming clock) reach timeout_cycles.
  task automatic model_step(bit edge_now);
    longint d;
    if (result_ack && m_valid) begin
      m_valid = 0;
      m_lost = 0;
    end
    if (edge_now) m_miss = 0;
    if (!enable) begin
      m_open = 0;
    end else if (edge_now) begin
      if (m_open && m_nedges == m_glen) begin
        d = n - m_topen;
        m_lost = m_lost | m_valid;
        m_res = (d > MAXC) ? MAXC : d;
        m_ovf = d > MAXC;
        m_valid = 1;
        m_open = 0;
      end
      if (m_open) m_nedges++;
      else begin
        m_open = 1; m_topen = n; m_nedges = 0; m_glen = int'(gate_intervals);
      end
    end else if (m_open && timeout_cycles != 0 && longint'(n - m_last + 1) >= longint'(timeout_cycles)) begin
      m_open = 0;
      m_miss = 1;
    end
    if (edge_now) m_last = n;
  endtask

  // pps_in is raised 4 clocks before the clock at which the counter consumes the edge
  task automatic step();
    pps_in = (n >= next_e - 4) && (n < next_e - 2);
    @(posedge clk);
    #1;
    n++;
    model_step(n == next_e);
    result_ack = 1'b0;
    check("outputs", pack(result, result_valid, result_overflow, result_lost, pps_missing),
          pack(m_res[CW-1:0], m_valid, m_ovf, m_lost, m_miss));
  endtask

  task automatic edge_after(int gap, bit ack_last = 0, bit rnd = 0);
    next_e = last_e + gap;
    while (n < next_e) begin
      if (rnd) begin
        result_ack = $urandom_range(0, 99) == 0;
        enable = $urandom_range(0, 399) != 0;
      end
      if (ack_last && n == next_e - 1) result_ack = 1'b1;
      step();
    end
    last_e = next_e;
    next_e = FAR;
  endtask

  task automatic do_reset();
    pps_in = 1'b0;
    next_e = FAR;
    reset_n = 1'b0;
    #1;
    check("reset", pack(result, result_valid, result_overflow, result_lost, pps_missing), '0);
    repeat (3) begin
      @(posedge clk);
      n++;
    end
    #1;
    reset_n = 1'b1;
    model_reset();
    last_e = n;
  endtask

  initial begin
    int gap;
    //            gi  sp    ne  tmo  tail res   v  o  m
    tbl[0]  = '{0,  1000, 2,  0,   0,   1000, 1, 0, 0};
    tbl[1]  = '{3,  250,  5,  0,   0,   1000, 1, 0, 0};
    tbl[2]  = '{0,  1100, 2,  0,   0,   1023, 1, 1, 0};
    tbl[3]  = '{0,  1023, 2,  0,   0,   1023, 1, 0, 0};
    tbl[4]  = '{0,  1024, 2,  0,   0,   1023, 1, 1, 0};
    tbl[5]  = '{1,  600,  3,  0,   0,   1023, 1, 1, 0};
    tbl[6]  = '{15, 60,   17, 0,   0,   960,  1, 0, 0};
    tbl[7]  = '{2,  7,    4,  0,   0,   21,   1, 0, 0};
    tbl[8]  = '{0,  499,  2,  500, 0,   499,  1, 0, 0};
    tbl[9]  = '{0,  0,    1,  500, 499, 0,    0, 0, 1};
    tbl[10] = '{0,  0,    1,  500, 498, 0,    0, 0, 0};
    tbl[11] = '{0,  500,  2,  500, 0,   0,    0, 0, 0};
    tbl[12] = '{1,  300,  2,  0,   50,  0,    0, 0, 0};

    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      do_reset();
      enable = 1'b1;
      gate_intervals = GW'(tbl[i].gi);
      timeout_cycles = TW'(tbl[i].tmo);
      edge_after(6);
      for (int j = 1; j < tbl[i].ne; j++) edge_after(tbl[i].sp);
      repeat (tbl[i].tail) step();
      check($sformatf("vec%0d", i), pack(result, result_valid, result_overflow, result_lost, pps_missing),
            pack(CW'(tbl[i].res), tbl[i].valid != 0, tbl[i].ovf != 0, 1'b0, tbl[i].miss != 0));
    end

    // back-to-back gates lose no cycles between them
    do_reset();
    enable = 1'b1; gate_intervals = '0; timeout_cycles = '0;
    edge_after(6);
    edge_after(1000);
    want("b2b_first", 1000, 1, 0, 0, 0);
    edge_after(1000);
    want("b2b_second", 1000, 1, 0, 1, 0);

    // overwrite, ack, ack with no data, ack coincident with a gate close
    do_reset();
    enable = 1'b1;
    edge_after(6);
    edge_after(100);
    edge_after(200);
    edge_after(300);
    want("lost_third", 300, 1, 0, 1, 0);
    result_ack = 1'b1;
    step();
    want("ack_clears", 300, 0, 0, 0, 0);
    result_ack = 1'b1;
    step();
    want("ack_ignored", 300, 0, 0, 0, 0);
    edge_after(150, 1);
    want("ack_at_close_idle", 150, 1, 0, 0, 0);
    edge_after(250, 1);
    want("ack_at_close_valid", 250, 1, 0, 0, 0);

    // enable dropped for one cycle mid-gate
    do_reset();
    enable = 1'b1;
    edge_after(6);
    repeat (100) step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    edge_after(150);
    want("abort_no_result", 0, 0, 0, 0, 0);
    edge_after(400);
    want("abort_next_gate", 400, 1, 0, 0, 0);

    // reset mid-gate needs a fresh opening edge
    do_reset();
    enable = 1'b1;
    edge_after(6);
    repeat (100) step();
    do_reset();
    enable = 1'b1;
    edge_after(6);
    want("rst_no_result", 0, 0, 0, 0, 0);
    edge_after(300);
    want("rst_next_gate", 300, 1, 0, 0, 0);

    // timeout, then the next edge clears pps_missing and restarts
    do_reset();
    enable = 1'b1; timeout_cycles = TW'(500);
    edge_after(6);
    repeat (600) step();
    want("timeout_missing", 0, 0, 0, 0, 1);
    edge_after(700);
    want("timeout_cleared", 0, 0, 0, 0, 0);
    edge_after(300);
    want("timeout_restart", 300, 1, 0, 0, 0);

    // gate_intervals change only applies at the next gate open
    do_reset();
    enable = 1'b1; timeout_cycles = '0; gate_intervals = GW'(3);
    edge_after(6);
    edge_after(100);
    gate_intervals = '0;
    edge_after(100);
    edge_after(100);
    want("gi_held_open", 0, 0, 0, 0, 0);
    edge_after(100);
    want("gi_old_len", 400, 1, 0, 0, 0);
    edge_after(50);
    want("gi_new_len", 50, 1, 0, 1, 0);

    // random traffic against the model
    do_reset();
    enable = 1'b1;
    for (int ep = 0; ep < 60; ep++) begin
      gate_intervals = GW'($urandom_range(0, 3));
      timeout_cycles = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(200, 900));
      gap = $urandom_range(6, 700);
      edge_after(gap, 0, 1);
      enable = 1'b1;
    end
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pps_frequency_counter.md
Name: pps_frequency_counter

Overview:
Measures the reference clock against the GPS pulse-per-second input by counting system_clk cycles over a programmable number of PPS intervals. It is the parametrised successor of the inline GPS gate counter in the top level, and adds the following:
- synchronised edge detection
- saturation and overflow flagging
- missing-pulse timeout
- enable/abort control
- a valid/ack result handshake with overrun detection

The SPI register map reads the result and acknowledges it; the top level instantiates one block per disciplined clock.

Parameters:
COUNT_WIDTH, 36, width of cycle counter and result
GATE_WIDTH, 4, width of gate_intervals input
SYNC_STAGES, 2, flip-flops in the pps_in synchroniser (min 2)
TIMEOUT_WIDTH, 32, width of timeout_cycles input

Ports:
system_clk  input  1  sole clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  run measurement; low aborts and idles
pps_in  input  1  raw asynchronous GPS pulse
gate_intervals  input  GATE_WIDTH  PPS intervals per measurement minus 1
timeout_cycles  input  TIMEOUT_WIDTH  max cycles between PPS edges before declaring missing
result  output  COUNT_WIDTH  cycles counted over the last completed gate
result_valid  output  1  result holds unacknowledged data
result_ack  input  1  consumer acknowledges result (single-cycle pulse)
result_overflow  output  1  result saturated (qualifies result)
result_lost  output  1  sticky: a result was overwritten before ack
pps_missing  output  1  timeout expired since last edge

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchroniser 0.
- Edge detect: pps_in passes through a SYNC_STAGES chain plus one history flop. pps_edge is a one-cycle pulse on the 0->1 transition. Latency from pin to pps_edge is SYNC_STAGES+1 cycles.
- FSM states:
  - IDLE: wait for pps_edge with enable=1. On the edge, go to COUNTING; cnt<=0, intervals<=0, gate_len<=gate_intervals (sampled), since_edge<=0.
  - COUNTING, no edge: cnt<=cnt+1, saturating at all-ones; when it saturates, set internal ovf.
  - COUNTING, edge with intervals<gate_len: intervals++, cnt++ (saturating).
  - COUNTING, edge with intervals==gate_len: gate closes.
    - result<=sat(cnt+1); result_overflow<=ovf|saturated.
    - Next gate opens in the same cycle: cnt<=0, intervals<=0, ovf<=0, gate_len re-sampled.
    - result therefore equals the cycle distance between the opening and closing edge-detect cycles.
- since_edge: clears on every pps_edge and otherwise increments, saturating. On reaching timeout_cycles while in COUNTING:
  - pps_missing<=1, state<=IDLE, partial count discarded, no result produced.
  - pps_missing clears on the next pps_edge.
  - timeout_cycles==0 disables the timeout.
- enable low in any state: go to IDLE next cycle, discard partial count. Result, result_valid, result_lost and pps_missing are held.
- Handshake:
  - A gate close sets result_valid.
  - result_ack with result_valid=1 clears result_valid and result_lost.
  - result_ack with result_valid=0 is ignored.
  - Gate close while result_valid=1 and no ack: result is overwritten and result_lost<=1.
  - Gate close in the same cycle as result_ack: the new result wins, result_valid stays 1, result_lost is cleared (ack takes effect first).
- gate_intervals changes take effect only at the next gate open.
- Reset asserted mid-gate: immediate return to reset values; the first measurement after release requires a fresh opening edge.
- Arithmetic is unsigned. No wrap-around anywhere: every counter saturates.

Decomposition:
- Shared package: FSM state encoding (IDLE, COUNTING) and a localparam for counter all-ones derived from COUNT_WIDTH.
- One sub-module is natural: pulse_synchronizer (parameter SYNC_STAGES; outputs synced level and rising-edge pulse), reusable for button and encoder inputs.
- Saturating increment stays inline.

Test Plan:
- gate_intervals=0, PPS edges 1000 cycles apart, timeout 0 -> result=1000 and result_valid=1 after the second edge. Subsequent results are 1000 back-to-back, with no cycle lost between gates.
- gate_intervals=3, edges 250 cycles apart -> first result 1000 at the 5th edge; result_overflow=0.
- COUNT_WIDTH=8, gate_intervals=0, edges 300 apart -> result=255, result_overflow=1. The next gate is at 200 spacing -> result=200, result_overflow=0.
- Three results delivered with no ack -> result_lost=1 and result equals the third value. Then ack -> result_valid=0 and result_lost=0. Ack coincident with the 4th gate close -> result_valid=1, result_lost=0.
- timeout_cycles=500, one edge then silence -> pps_missing=1 exactly 500 cycles after the edge-detect cycle, with no result. The next edge clears pps_missing and restarts measurement.
- enable dropped mid-gate for 1 cycle, or reset_n pulsed low -> no result from the aborted gate. The next result spans only edges seen after re-entry to COUNTING.
